// File: rtl/lfsr_ctrl_pkg.sv
// Shared types and constants for the lfsr_ctrl block: FSM state encoding,
// LFSR reset value and default feedback taps.
package lfsr_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] LFSR_RST_VAL = 4'b0001;
  localparam logic [3:0] TAPS_DEFAULT = 4'b1100;

endpackage

// File: rtl/lfsr_ctrl_step.sv
// 4-bit Fibonacci LFSR register: synchronous reset, seed load (zero seed
// replaced by the reset value to avoid lock-up) and single-step advance.
module lfsr_step
  import lfsr_ctrl_pkg::*;
#(
  parameter logic [3:0] TAPS = TAPS_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       enable,
  input  logic [3:0] seed,
  output logic [3:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= LFSR_RST_VAL;
    end else if (load) begin
      q <= (seed == '0) ? LFSR_RST_VAL : seed;
    end else if (enable) begin
      q <= {q[2:0], ^(q & TAPS)};
    end
  end

endmodule

// File: rtl/lfsr_ctrl.sv
// Run controller handing out LFSR words to two round-robin requesters.
// Define LFSR_CTRL_FREERUN_EN to advance the LFSR every RUN cycle instead of per grant.
module lfsr_ctrl
  import lfsr_ctrl_pkg::*;
#(
  parameter logic [3:0] TAPS  = TAPS_DEFAULT,
  parameter int         CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             seed_load,
  input  logic [3:0]       seed,
  input  logic             start,
  input  logic [CNT_W-1:0] steps,
  input  logic [1:0]       req,
  output logic [1:0]       gnt,
  output logic [3:0]       rdata,
  output logic             rvalid,
  output logic             busy,
  output logic             done
);

  state_t           state;
  logic [CNT_W-1:0] count;
  logic             rr_ptr;
  logic [3:0]       q;
  logic             lfsr_load;
  logic             lfsr_en;
  logic             grant;
  logic [1:0]       pick;

  always_comb begin
    lfsr_load = (state == IDLE) && seed_load;
    grant     = (state == RUN) && (req != '0) && (count != '0);
    // rr_ptr names the requester favoured on a tie; a lone request wins outright
    if (req == 2'b11) pick = rr_ptr ? 2'b10 : 2'b01;
    else              pick = req;
`ifdef LFSR_CTRL_FREERUN_EN
    lfsr_en = (state == RUN);
`else
    lfsr_en = grant;
`endif
  end

  lfsr_step #(.TAPS(TAPS)) u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .load   (lfsr_load),
    .enable (lfsr_en),
    .seed   (seed),
    .q      (q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      count  <= '0;
      rr_ptr <= 1'b0;
      gnt    <= '0;
      rvalid <= 1'b0;
      rdata  <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      gnt    <= '0;
      rvalid <= 1'b0;
      rdata  <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (steps != '0) begin
              state <= RUN;
              count <= steps;
              busy  <= 1'b1;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        RUN: begin
          busy <= 1'b1;
          if (grant) begin
            gnt    <= pick;
            rvalid <= 1'b1;
            rdata  <= q;
            count  <= count - CNT_W'(1);
            rr_ptr <= pick[0];
            // final grant and done pulse land in the same cycle
            if (count == CNT_W'(1)) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lfsr_ctrl.sv
// Directed self-checking bench for lfsr_ctrl.
module tb_lfsr_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       seed_load = 1'b0;
  logic [3:0] seed = '0;
  logic       start = 1'b0;
  logic [7:0] steps = '0;
  logic [1:0] req = '0;
  logic [1:0] gnt;
  logic [3:0] rdata;
  logic       rvalid;
  logic       busy;
  logic       done;

  int tests = 0;
  int fails = 0;

  // Hand-computed period-15 sequence of x^4+x^3+1 starting at 0001
  logic [3:0] seq [15] = '{4'b0001, 4'b0010, 4'b0100, 4'b1001, 4'b0011,
                           4'b0110, 4'b1101, 4'b1010, 4'b0101, 4'b1011,
                           4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000};

  lfsr_ctrl #(.TAPS(4'b1100), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .seed_load (seed_load),
    .seed      (seed),
    .start     (start),
    .steps     (steps),
    .req       (req),
    .gnt       (gnt),
    .rdata     (rdata),
    .rvalid    (rvalid),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; seed_load = 1'b0; start = 1'b0; req = '0; steps = '0; seed = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 2'b11; start = 1'b1; seed_load = 1'b1; seed = 4'b0110; steps = 8'd3;
    tick();
    tests++;
    if ({gnt, rvalid, rdata, busy, done} !== 9'b0) begin
      fails++;
      $display("FAIL reset_outputs got gnt=%b rvalid=%b rdata=%b busy=%b done=%b want all 0",
               gnt, rvalid, rdata, busy, done);
    end
    rst = 1'b0; req = '0; start = 1'b0; seed_load = 1'b0;
  endtask

  task automatic test_basic();
    do_reset();
    seed_load = 1'b1; seed = 4'b0001; start = 1'b1; steps = 8'd4; req = 2'b01;
    tick();
    seed_load = 1'b0; start = 1'b0;
    tests++;
    if (busy !== 1'b1 || gnt !== 2'b00) begin
      fails++; $display("FAIL basic_accept got busy=%b gnt=%b want 1 00", busy, gnt);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      tests++;
      if (gnt !== 2'b01 || rdata !== seq[i] || rvalid !== 1'b1 ||
          done !== (i == 3) || busy !== (i < 3)) begin
        fails++;
        $display("FAIL basic_word%0d got gnt=%b rdata=%b rvalid=%b done=%b busy=%b want 01 %b 1 %b %b",
                 i, gnt, rdata, rvalid, done, busy, seq[i], (i == 3), (i < 3));
      end
    end
    tick();
    tests++;
    if ({gnt, rvalid, busy, done} !== 5'b0) begin
      fails++; $display("FAIL basic_after got gnt=%b rvalid=%b busy=%b done=%b want 0", gnt, rvalid, busy, done);
    end
    req = '0;
  endtask

  task automatic test_period();
    do_reset();
    seed_load = 1'b1; seed = 4'b0000; start = 1'b1; steps = 8'd15; req = 2'b01;
    tick();
    seed_load = 1'b0; start = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      tests++;
      if (rdata !== seq[i] || gnt !== 2'b01) begin
        fails++; $display("FAIL period_word%0d got rdata=%b gnt=%b want %b 01", i, rdata, gnt, seq[i]);
      end
    end
    tests++;
    if (done !== 1'b1) begin
      fails++; $display("FAIL period_done got %b want 1", done);
    end
    tick();
    start = 1'b1; steps = 8'd1;
    tick();
    start = 1'b0;
    tick();
    tests++;
    if (rdata !== 4'b0001 || done !== 1'b1) begin
      fails++; $display("FAIL period_wrap got rdata=%b done=%b want 0001 1", rdata, done);
    end
    req = '0;
    tick();
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_g [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    do_reset();
    seed_load = 1'b1; seed = 4'b0001; start = 1'b1; steps = 8'd4; req = 2'b11;
    tick();
    seed_load = 1'b0; start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      tests++;
      if (gnt !== exp_g[i] || rdata !== seq[i]) begin
        fails++; $display("FAIL rr_word%0d got gnt=%b rdata=%b want %b %b", i, gnt, rdata, exp_g[i], seq[i]);
      end
    end
    req = '0;
    tick();
  endtask

  task automatic test_zero_steps();
    do_reset();
    start = 1'b1; steps = 8'd0; req = 2'b01;
    tick();
    start = 1'b0;
    tests++;
    if (done !== 1'b1 || gnt !== 2'b00 || busy !== 1'b0) begin
      fails++; $display("FAIL zero_done got done=%b gnt=%b busy=%b want 1 00 0", done, gnt, busy);
    end
    tick();
    tests++;
    if (done !== 1'b0 || gnt !== 2'b00) begin
      fails++; $display("FAIL zero_idle got done=%b gnt=%b want 0 00", done, gnt);
    end
    start = 1'b1; steps = 8'd1;
    tick();
    start = 1'b0;
    tick();
    tests++;
    if (rdata !== 4'b0001 || gnt !== 2'b01) begin
      fails++; $display("FAIL zero_lfsr_hold got rdata=%b gnt=%b want 0001 01", rdata, gnt);
    end
    req = '0;
    tick();
  endtask

  task automatic test_gaps(input int abort_after);
    do_reset();
    seed_load = 1'b1; seed = 4'b0001; start = 1'b1; steps = 8'd8;
    tick();
    seed_load = 1'b0; start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (k == abort_after) begin
        rst = 1'b1; req = 2'b01;
        tick();
        rst = 1'b0; req = '0;
        tests++;
        if ({gnt, rvalid, rdata, busy, done} !== 9'b0) begin
          fails++; $display("FAIL abort_outputs got gnt=%b rvalid=%b rdata=%b busy=%b done=%b want all 0",
                            gnt, rvalid, rdata, busy, done);
        end
        tick();
        tests++;
        if (done !== 1'b0 || busy !== 1'b0) begin
          fails++; $display("FAIL abort_nodone got done=%b busy=%b want 0 0", done, busy);
        end
        return;
      end
      req = '0;
      for (int g = 0; g < 3; g++) begin
        seed_load = (g == 1); seed = 4'b1111; start = (g == 2);
        tick();
        tests++;
        if (gnt !== 2'b00 || busy !== 1'b1) begin
          fails++; $display("FAIL gap_w%0d_c%0d got gnt=%b busy=%b want 00 1", k, g, gnt, busy);
        end
      end
      seed_load = 1'b0; start = 1'b0; req = 2'b01;
      tick();
      tests++;
      if (rdata !== seq[k] || gnt !== 2'b01 || done !== (k == 7)) begin
        fails++; $display("FAIL gap_word%0d got rdata=%b gnt=%b done=%b want %b 01 %b",
                          k, rdata, gnt, done, seq[k], (k == 7));
      end
    end
    req = '0;
    tick();
  endtask

  task automatic test_freerun();
    do_reset();
    seed_load = 1'b1; seed = 4'b0001; start = 1'b1; steps = 8'd2;
    tick();
    seed_load = 1'b0; start = 1'b0;
    tick();
    tick();
    req = 2'b01;
    tick();
    tests++;
    if (rdata !== 4'b0100 || gnt !== 2'b01) begin
      fails++; $display("FAIL freerun_first got rdata=%b gnt=%b want 0100 01", rdata, gnt);
    end
    tick();
    tests++;
    if (rdata !== 4'b1001 || done !== 1'b1) begin
      fails++; $display("FAIL freerun_second got rdata=%b done=%b want 1001 1", rdata, done);
    end
    req = '0;
    tick();
  endtask

  initial begin
    test_reset();
`ifdef LFSR_CTRL_FREERUN_EN
    test_freerun();
`else
    test_basic();
    test_period();
    test_round_robin();
    test_zero_steps();
    test_gaps(8);
    test_gaps(5);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/lfsr_ctrl.md
LFSR_CTRL -- requirements
Module: lfsr_ctrl

Interface
REQ-001 Parameter TAPS, default 4'b1100, feedback taps of the 4-bit Fibonacci LFSR (x^4+x^3+1): next = {q[2:0], q[3]^q[2]}.
REQ-002 Parameter CNT_W, default 8, width of the step counter.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 seed_load  input  1  load seed into the LFSR; honoured only in IDLE.
REQ-006 seed  input  4  seed value.
REQ-007 start  input  1  begin a run of `steps` grants; honoured only in IDLE.
REQ-008 steps  input  CNT_W  number of words to hand out in the run; sampled when start is accepted.
REQ-009 req  input  2  per-requester request level; held high until granted.
REQ-010 gnt  output  2  one-hot registered grant, one-cycle pulse.
REQ-011 rdata  output  4  LFSR word for the granted requester; valid while rvalid=1.
REQ-012 rvalid  output  1  registered; equals |gnt.
REQ-013 busy  output  1  high while in RUN.
REQ-014 done  output  1  one-cycle pulse at end of run.

Function
REQ-015 FSM states IDLE, RUN, DONE; IDLE->RUN on start with steps!=0; IDLE->DONE on start with steps==0; RUN->DONE on the cycle the final grant issues; DONE->IDLE unconditionally after one cycle.
REQ-016 In IDLE, seed_load loads seed into the LFSR next edge; seed==0 loads 4'b0001 instead (lock-up avoidance).
REQ-017 seed_load and start both high in IDLE: seed loads, start accepted same edge; first grant word is the new seed.
REQ-018 seed_load and start in RUN or DONE are ignored with no side effects.
REQ-019 In RUN, at each edge with req!=0 and remaining count>0, exactly one requester is granted; gnt, rdata (current LFSR value), rvalid appear in the cycle after that edge (latency 1).
REQ-020 Arbitration is round-robin: when both request, the requester not granted most recently wins; a lone requester wins every cycle.
REQ-021 On each grant the LFSR advances one step and the remaining count decrements by one; no grant means LFSR and count hold.
REQ-022 done is high exactly in DONE; busy is high exactly in RUN; gnt/rvalid are zero outside grant cycles.
REQ-023 The last grant of a run and the done pulse are in the same cycle.

Reset
REQ-024 rst high at an edge: state IDLE, LFSR=4'b0001, count=0, round-robin pointer favours requester 0, gnt=0, rvalid=0, rdata=0, busy=0, done=0.
REQ-025 rst mid-run aborts the run with no done pulse; rst has priority over every other input.

Configuration
REQ-026 Macro LFSR_CTRL_FREERUN_EN: when defined, the LFSR advances every cycle while in RUN regardless of grants (count still decrements only on grants); when undefined, REQ-021 applies.

Structure
REQ-027 Shared package lfsr_ctrl_pkg holds the state enum (IDLE, RUN, DONE), LFSR_RST_VAL=4'b0001 and default TAPS.
REQ-028 LFSR register and next-state logic in sub-module lfsr_step (load, enable, seed, q); FSM, counter and arbiter in lfsr_ctrl.

Verification
REQ-029 Reset, seed_load seed=0001, start steps=4, req=01 held -> rdata 0001,0010,0100,1001 on four consecutive cycles, gnt=01 each, done with 4th word, busy low next cycle.
REQ-030 seed=0000 load, start steps=15, req=01 -> first word 0001, 15 words match period-15 sequence, 16th (after restart) repeats 0001.
REQ-031 req=11 held, steps=4 -> gnt 01,10,01,10; rdata 0001,0010,0100,1001.
REQ-032 start steps=0 -> done one cycle later, no gnt, LFSR unchanged.
REQ-033 Run steps=8, req gaps of 3 idle cycles, seed_load=1 seed=1111 mid-run -> LFSR holds during gaps, seed ignored, 8 words in sequence; rst asserted after 5th word -> outputs zeroed, no done.
REQ-034 With LFSR_CTRL_FREERUN_EN, seed 0001, start steps=2, req=01 first asserted 2 cycles after start -> first word 0100.
